// File: rtl/conv_seq_pkg.sv
// ---------------------------------------------------------------------------
// conv_seq_pkg
//   Shared types and width helpers for the convolution window sequencer.
//   - state_t : sequencer FSM states
//   - idx_w   : bits needed to index n items (at least 1)
//   - fmap_aw : feature RAM address width for a KC x H x W map
//   - wgt_aw  : weight RAM address width for a KC x KH x KW kernel
// ---------------------------------------------------------------------------
package conv_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        WRITE,
        DONE
    } state_t;

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int fmap_aw(input int kc, input int h, input int w);
        return idx_w(kc * h * w);
    endfunction

    function automatic int wgt_aw(input int kc, input int kh, input int kw);
        return idx_w(kc * kh * kw);
    endfunction

endpackage

// File: rtl/mac_unit.sv
// ---------------------------------------------------------------------------
// mac_unit
//   Registered signed multiply-accumulate. Full-width product, wrapping
//   two's-complement accumulator of 2*DATA_W bits.
//   clk, reset : clock, synchronous active-high reset (clears accumulator)
//   en         : accept a product this cycle
//   first      : load the accumulator with the product instead of adding
//   a, b       : signed operands
//   acc        : accumulator value (held while en is low)
// ---------------------------------------------------------------------------
module mac_unit #(
    parameter int DATA_W = 17
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       first,
    input  logic signed [DATA_W-1:0]   a,
    input  logic signed [DATA_W-1:0]   b,
    output logic signed [2*DATA_W-1:0] acc
);

    logic signed [2*DATA_W-1:0] w_prod_p1;
    logic signed [2*DATA_W-1:0] r_acc_p2;

    // operands are sign-extended to the product width before multiplying
    assign w_prod_p1 = a * b;

    // stage p1 -> p2: accumulate
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc_p2 <= '0;
        end else if (en) begin
            r_acc_p2 <= first ? w_prod_p1 : (r_acc_p2 + w_prod_p1);
        end
    end

    assign acc = r_acc_p2;

endmodule

// File: rtl/conv_window_sequencer.sv
// ---------------------------------------------------------------------------
// conv_window_sequencer
//   Walks every output position of a convolution layer and, per position,
//   issues one feature/weight read per kernel term (channel/row/column order),
//   feeds the MAC, then presents the dot product on a valid/ready port.
//   clk, reset           : clock, synchronous active-high reset
//   start                : one-cycle layer request (ignored while busy)
//   busy                 : layer in progress
//   done                 : one-cycle pulse after the last output handshake
//   rd_en                : read strobe to both RAMs
//   fmap_addr, wgt_addr  : RAM addresses for the current term
//   fmap_data, wgt_data  : RAM read data, one cycle after rd_en
//   out_valid, out_ready : result handshake
//   out_data             : signed dot product
//   out_row, out_col     : output position of out_data
// ---------------------------------------------------------------------------
module conv_window_sequencer
    import conv_seq_pkg::*;
#(
    parameter int kernal_height  = 5,
    parameter int kernal_width   = 5,
    parameter int kernal_channel = 3,
    parameter int in_height      = 32,
    parameter int in_width       = 32,
    parameter int bitwidth       = 17
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [fmap_aw(kernal_channel, in_height, in_width)-1:0]         fmap_addr,
    output logic [wgt_aw(kernal_channel, kernal_height, kernal_width)-1:0]  wgt_addr,
    input  logic signed [bitwidth-1:0]   fmap_data,
    input  logic signed [bitwidth-1:0]   wgt_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [2*bitwidth-1:0] out_data,
    output logic [idx_w(in_height - kernal_height + 1)-1:0] out_row,
    output logic [idx_w(in_width - kernal_width + 1)-1:0]   out_col
);

    localparam int KH    = kernal_height;
    localparam int KW    = kernal_width;
    localparam int KC    = kernal_channel;
    localparam int H     = in_height;
    localparam int W     = in_width;
    localparam int OH    = H - KH + 1;
    localparam int OW    = W - KW + 1;
    localparam int FA_W  = fmap_aw(KC, H, W);
    localparam int WA_W  = wgt_aw(KC, KH, KW);
    localparam int KX_W  = idx_w(KW);
    localparam int KY_W  = idx_w(KH);
    localparam int C_W   = idx_w(KC);
    localparam int ROW_W = idx_w(OH);
    localparam int COL_W = idx_w(OW);

    localparam logic [KX_W-1:0]  KX_LAST  = KX_W'(KW - 1);
    localparam logic [KY_W-1:0]  KY_LAST  = KY_W'(KH - 1);
    localparam logic [C_W-1:0]   C_LAST   = C_W'(KC - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OH - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(OW - 1);

    state_t           r_state;
    logic [KX_W-1:0]  r_kx;
    logic [KY_W-1:0]  r_ky;
    logic [C_W-1:0]   r_c;
    logic [COL_W-1:0] r_ox;
    logic [ROW_W-1:0] r_oy;
    logic             r_rd_en;
    logic             r_busy;
    logic             r_done;
    logic             r_out_valid;
    logic             r_tag_en_p1;
    logic             r_tag_first_p1;

    logic w_first_term;
    logic w_last_term;
    logic w_last_pos;

    assign w_first_term = (r_kx == '0) && (r_ky == '0) && (r_c == '0);
    assign w_last_term  = (r_kx == KX_LAST) && (r_ky == KY_LAST) && (r_c == C_LAST);
    assign w_last_pos   = (r_ox == COL_LAST) && (r_oy == ROW_LAST);

    // Address arithmetic is done modulo 2^width; the true address always fits,
    // so truncated constant factors still give the exact result.
    assign fmap_addr = FA_W'(r_c) * FA_W'(H * W)
                     + (FA_W'(r_oy) + FA_W'(r_ky)) * FA_W'(W)
                     + FA_W'(r_ox) + FA_W'(r_kx);
    assign wgt_addr  = WA_W'(r_c) * WA_W'(KH * KW)
                     + WA_W'(r_ky) * WA_W'(KW)
                     + WA_W'(r_kx);

    // stage p0 -> p1: FSM, counters, and the tag delay that lines the
    // load/accumulate control up with RAM data arriving one cycle later
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_kx           <= '0;
            r_ky           <= '0;
            r_c            <= '0;
            r_ox           <= '0;
            r_oy           <= '0;
            r_rd_en        <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_out_valid    <= 1'b0;
            r_tag_en_p1    <= 1'b0;
            r_tag_first_p1 <= 1'b0;
        end else begin
            r_tag_en_p1    <= 1'b0;
            r_tag_first_p1 <= 1'b0;
            r_done         <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= RUN;
                        r_rd_en <= 1'b1;
                        r_busy  <= 1'b1;
                        r_kx    <= '0;
                        r_ky    <= '0;
                        r_c     <= '0;
                        r_ox    <= '0;
                        r_oy    <= '0;
                    end
                end
                RUN: begin
                    r_tag_en_p1    <= 1'b1;
                    r_tag_first_p1 <= w_first_term;
                    if (w_last_term) begin
                        r_state <= DRAIN;
                        r_rd_en <= 1'b0;
                        r_kx    <= '0;
                        r_ky    <= '0;
                        r_c     <= '0;
                    end else if (r_kx != KX_LAST) begin
                        r_kx <= r_kx + KX_W'(1);
                    end else begin
                        r_kx <= '0;
                        if (r_ky != KY_LAST) begin
                            r_ky <= r_ky + KY_W'(1);
                        end else begin
                            r_ky <= '0;
                            r_c  <= r_c + C_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    r_state     <= WRITE;
                    r_out_valid <= 1'b1;
                end
                WRITE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_last_pos) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_ox    <= '0;
                            r_oy    <= '0;
                        end else begin
                            r_state <= RUN;
                            r_rd_en <= 1'b1;
                            if (r_ox != COL_LAST) begin
                                r_ox <= r_ox + COL_W'(1);
                            end else begin
                                r_ox <= '0;
                                r_oy <= r_oy + ROW_W'(1);
                            end
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    mac_unit #(
        .DATA_W (bitwidth)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .en    (r_tag_en_p1),
        .first (r_tag_first_p1),
        .a     (fmap_data),
        .b     (wgt_data),
        .acc   (out_data)
    );

    assign busy      = r_busy;
    assign done      = r_done;
    assign rd_en     = r_rd_en;
    assign out_valid = r_out_valid;
    assign out_row   = r_oy;
    assign out_col   = r_ox;

endmodule
